// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Round-robin sequencer/arbiter for two memory requesters: requester 0 is
// instruction fetch, requester 1 is data load/store. It sits in front of the
// MAR / MDR / 512-word RAM subsystem. It grants one requester, latches that
// request, then steps through the MAR load, the MDR load and the RAM strobes.
// For a read it also captures the MDR output.
//
// Ports
//   clk                 system clock, all state changes on posedge
//   clr                 asynchronous active-low reset
//   rX_req/we/addr/wdata  requester X request (level), direction, address, data
//   rX_gnt              one-cycle pulse: request X accepted
//   rX_done             one-cycle pulse: access X complete
//   rdata               captured read data, held until the next capture
//   busy                high whenever the sequencer is not idle
//   bus_out/bus_drive   value driven onto the shared bus and its enable
//   MARin/MDRin         MAR and MDR load strobes
//   read/write          RAM read (MDR source = memory) and RAM write strobes
//   mdr_data            MDR output path from the memory subsystem
//
// Parameters
//   RD_CYCLES (1..7)    cycles that read+MDRin are held
//   WR_CYCLES (1..7)    cycles that write is held
module mem_access_ctrl #(
  parameter int unsigned RD_CYCLES = 1,
  parameter int unsigned WR_CYCLES = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic [8:0]  r0_addr,
  input  logic [31:0] r0_wdata,
  output logic        r0_gnt,
  output logic        r0_done,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic [8:0]  r1_addr,
  input  logic [31:0] r1_wdata,
  output logic        r1_gnt,
  output logic        r1_done,
  output logic [31:0] rdata,
  output logic        busy,
  output logic [31:0] bus_out,
  output logic        bus_drive,
  output logic        MARin,
  output logic        MDRin,
  output logic        read,
  output logic        write,
  input  logic [31:0] mdr_data
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_MAR = 3'd1,
    S_WDATA    = 3'd2,
    S_WRITE    = 3'd3,
    S_READ     = 3'd4,
    S_RCAP     = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  localparam logic [2:0] RD_LAST = 3'(RD_CYCLES - 1);
  localparam logic [2:0] WR_LAST = 3'(WR_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        gsel_q, gsel_d;   // requester currently granted
  logic        last_q, last_d;   // last requester granted (tie breaker)
  logic        we_q, we_d;
  logic [8:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] bus_out_d;

  // Next-state, grant selection and request latching.
  always_comb begin
    state_d = state_q;
    cnt_d   = 3'd0;              // the counter restarts on every state entry
    gsel_d  = gsel_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (r0_req || r1_req) begin
          // On a tie, grant the requester that did not win last time.
          if (r0_req && r1_req) begin
            gsel_d = ~last_q;
          end else begin
            gsel_d = r1_req;
          end
          last_d  = gsel_d;
          we_d    = gsel_d ? r1_we    : r0_we;
          addr_d  = gsel_d ? r1_addr  : r0_addr;
          wdata_d = gsel_d ? r1_wdata : r0_wdata;
          state_d = S_LOAD_MAR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD_MAR: begin
        if (we_q) begin
          state_d = S_WDATA;
        end else begin
          state_d = S_READ;
        end
      end
      S_WDATA: state_d = S_WRITE;
      S_WRITE: begin
        if (cnt_q == WR_LAST) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_READ: begin
        if (cnt_q == RD_LAST) begin
          state_d = S_RCAP;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_RCAP:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus value for the state being entered; the address comes from the
  // freshly latched request so it appears together with MARin.
  always_comb begin
    case (state_d)
      S_LOAD_MAR: bus_out_d = {23'd0, addr_d};
      S_WDATA:    bus_out_d = wdata_q;
      default:    bus_out_d = 32'd0;
    endcase
  end

  // FSM state plus Moore outputs, registered from the state being entered.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= S_IDLE;
      cnt_q     <= 3'd0;
      gsel_q    <= 1'b0;
      last_q    <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= 9'd0;
      wdata_q   <= 32'd0;
      r0_gnt    <= 1'b0;
      r1_gnt    <= 1'b0;
      r0_done   <= 1'b0;
      r1_done   <= 1'b0;
      rdata     <= 32'd0;
      busy      <= 1'b0;
      bus_out   <= 32'd0;
      bus_drive <= 1'b0;
      MARin     <= 1'b0;
      MDRin     <= 1'b0;
      read      <= 1'b0;
      write     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gsel_q    <= gsel_d;
      last_q    <= last_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      r0_gnt    <= (state_d == S_LOAD_MAR) && !gsel_d;
      r1_gnt    <= (state_d == S_LOAD_MAR) &&  gsel_d;
      r0_done   <= (state_d == S_DONE) && !gsel_d;
      r1_done   <= (state_d == S_DONE) &&  gsel_d;
      busy      <= (state_d != S_IDLE);
      bus_out   <= bus_out_d;
      bus_drive <= (state_d == S_LOAD_MAR) || (state_d == S_WDATA);
      MARin     <= (state_d == S_LOAD_MAR);
      MDRin     <= (state_d == S_WDATA) || (state_d == S_READ);
      read      <= (state_d == S_READ);
      write     <= (state_d == S_WRITE);
      // mdr_data holds the RAM word during RCAP and is captured on leaving it.
      if (state_q == S_RCAP) begin
        rdata <= mdr_data;
      end else begin
        rdata <= rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  // Inputs to the default instance (m_) and the extended-cycle instance (x_).
  logic m_r0_req = 1'b0, m_r0_we = 1'b0, m_r1_req = 1'b0, m_r1_we = 1'b0;
  logic [8:0]  m_r0_addr = 9'd0, m_r1_addr = 9'd0;
  logic [31:0] m_r0_wdata = 32'd0, m_r1_wdata = 32'd0;
  logic x_r0_req = 1'b0, x_r0_we = 1'b0, x_r1_req = 1'b0, x_r1_we = 1'b0;
  logic [8:0]  x_r0_addr = 9'd0, x_r1_addr = 9'd0;
  logic [31:0] x_r0_wdata = 32'd0, x_r1_wdata = 32'd0;

  logic m_g0, m_g1, m_d0, m_d1, m_busy, m_bd, m_mar, m_mdr, m_rd, m_wr;
  logic [31:0] m_rdata, m_bus, m_mdr_data;
  logic x_g0, x_g1, x_d0, x_d1, x_busy, x_bd, x_mar, x_mdr, x_rd, x_wr;
  logic [31:0] x_rdata, x_bus, x_mdr_data;

  mem_access_ctrl dut (
    .clk(clk), .clr(clr),
    .r0_req(m_r0_req), .r0_we(m_r0_we), .r0_addr(m_r0_addr), .r0_wdata(m_r0_wdata),
    .r0_gnt(m_g0), .r0_done(m_d0),
    .r1_req(m_r1_req), .r1_we(m_r1_we), .r1_addr(m_r1_addr), .r1_wdata(m_r1_wdata),
    .r1_gnt(m_g1), .r1_done(m_d1),
    .rdata(m_rdata), .busy(m_busy), .bus_out(m_bus), .bus_drive(m_bd),
    .MARin(m_mar), .MDRin(m_mdr), .read(m_rd), .write(m_wr), .mdr_data(m_mdr_data)
  );

  mem_access_ctrl #(.RD_CYCLES(3), .WR_CYCLES(2)) dut_x (
    .clk(clk), .clr(clr),
    .r0_req(x_r0_req), .r0_we(x_r0_we), .r0_addr(x_r0_addr), .r0_wdata(x_r0_wdata),
    .r0_gnt(x_g0), .r0_done(x_d0),
    .r1_req(x_r1_req), .r1_we(x_r1_we), .r1_addr(x_r1_addr), .r1_wdata(x_r1_wdata),
    .r1_gnt(x_g1), .r1_done(x_d1),
    .rdata(x_rdata), .busy(x_busy), .bus_out(x_bus), .bus_drive(x_bd),
    .MARin(x_mar), .MDRin(x_mdr), .read(x_rd), .write(x_wr), .mdr_data(x_mdr_data)
  );

  // Behavioural MAR / MDR / RAM, one per instance.
  logic [31:0] mem_m [512];
  logic [31:0] mem_x [512];
  logic [8:0]  mar_m = 9'd0, mar_x = 9'd0;
  logic [31:0] mdr_m = 32'd0, mdr_x = 32'd0;
  assign m_mdr_data = mdr_m;
  assign x_mdr_data = mdr_x;

  always @(posedge clk) begin
    if (m_mar) mar_m <= m_bus[8:0];
    if (m_mdr) mdr_m <= m_rd ? mem_m[mar_m] : m_bus;
    if (m_wr)  mem_m[mar_m] <= mdr_m;
    if (x_mar) mar_x <= x_bus[8:0];
    if (x_mdr) mdr_x <= x_rd ? mem_x[mar_x] : x_bus;
    if (x_wr)  mem_x[mar_x] <= mdr_x;
  end

  // Observation mux: which instance the current sequence looks at.
  logic x_sel = 1'b0;
  logic o_g0, o_g1, o_d0, o_d1, o_busy, o_bd, o_mar, o_mdr, o_rd, o_wr;
  logic [31:0] o_rdata, o_bus;
  always_comb begin
    if (x_sel) begin
      {o_g0, o_g1, o_d0, o_d1, o_busy, o_bd, o_mar, o_mdr, o_rd, o_wr} =
        {x_g0, x_g1, x_d0, x_d1, x_busy, x_bd, x_mar, x_mdr, x_rd, x_wr};
      o_rdata = x_rdata;
      o_bus   = x_bus;
    end else begin
      {o_g0, o_g1, o_d0, o_d1, o_busy, o_bd, o_mar, o_mdr, o_rd, o_wr} =
        {m_g0, m_g1, m_d0, m_d1, m_busy, m_bd, m_mar, m_mdr, m_rd, m_wr};
      o_rdata = m_rdata;
      o_bus   = m_bus;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic set_req(input bit x, input bit rq, input logic req, input logic we,
                         input logic [8:0] addr, input logic [31:0] wd);
    if (!x && !rq) begin
      m_r0_req = req; m_r0_we = we; m_r0_addr = addr; m_r0_wdata = wd;
    end else if (!x && rq) begin
      m_r1_req = req; m_r1_we = we; m_r1_addr = addr; m_r1_wdata = wd;
    end else if (x && !rq) begin
      x_r0_req = req; x_r0_we = we; x_r0_addr = addr; x_r0_wdata = wd;
    end else begin
      x_r1_req = req; x_r1_we = we; x_r1_addr = addr; x_r1_wdata = wd;
    end
  endtask

  typedef struct {
    bit          x;          // 1 = extended instance (RD 3, WR 2)
    bit          rq;         // requester
    logic        we;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;  // checked for reads only
    int          exp_done;   // cycle of rX_done after the sampling IDLE cycle
    int          exp_strb;   // cycles of read (reads) or write (writes)
  } vec_t;

  vec_t vecs [9];

  // One access; addr/wdata are inverted right after the grant, so the bus
  // and read-data checks also show that the request was latched.
  task automatic do_access(input vec_t v, input int idx);
    int gnt_cyc, done_cyc, strb, wrong, inv;
    logic [31:0] mar_val, wd_val, rd_at_done;
    logic my_g, my_d, ot_g, ot_d;
    gnt_cyc = 0; done_cyc = 0; strb = 0; wrong = 0; inv = 0;
    mar_val = 32'hFFFF_FFFF; wd_val = 32'hFFFF_FFFF; rd_at_done = 32'hFFFF_FFFF;
    x_sel = v.x;
    @(negedge clk);
    set_req(v.x, v.rq, 1'b1, v.we, v.addr, v.wdata);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      my_g = v.rq ? o_g1 : o_g0;  ot_g = v.rq ? o_g0 : o_g1;
      my_d = v.rq ? o_d1 : o_d0;  ot_d = v.rq ? o_d0 : o_d1;
      if (my_g && gnt_cyc == 0) begin
        gnt_cyc = k;
        set_req(v.x, v.rq, 1'b0, v.we, ~v.addr, ~v.wdata);
      end
      if (my_d && done_cyc == 0) begin
        done_cyc = k;
        rd_at_done = o_rdata;
      end
      if (ot_g || ot_d) wrong++;
      if (v.we ? o_wr : o_rd) strb++;
      if (o_mar) mar_val = o_bus;
      if (o_mdr && !o_rd) wd_val = o_bus;
      if ((o_rd && o_wr) || (o_mar && o_mdr) ||
          (o_bd && !(o_mar || (o_mdr && !o_rd)))) inv++;
    end
    chk($sformatf("v%0d_gnt_cycle", idx), gnt_cyc, 1);
    chk($sformatf("v%0d_done_cycle", idx), done_cyc, v.exp_done);
    chk($sformatf("v%0d_strobe_cycles", idx), strb, v.exp_strb);
    chk($sformatf("v%0d_mar_bus", idx), mar_val, {23'd0, v.addr});
    chk($sformatf("v%0d_wrong_requester", idx), wrong, 0);
    chk($sformatf("v%0d_invariants", idx), inv, 0);
    if (v.we) begin
      chk($sformatf("v%0d_wdata_bus", idx), wd_val, v.wdata);
    end else begin
      chk($sformatf("v%0d_rdata_at_done", idx), rd_at_done, v.exp_rdata);
      chk($sformatf("v%0d_rdata_held", idx), o_rdata, v.exp_rdata);
    end
  endtask

  initial begin
    int got_read, ev;
    int gc [4]; bit gw [4]; int ng;
    int d0c [2]; int d1c [2]; int n0, n1;
    logic [31:0] d0r [2]; logic [31:0] d1r [2];

    for (int i = 0; i < 512; i++) begin
      mem_m[i] = 32'd0;
      mem_x[i] = 32'd0;
    end
    //           x     rq    we    addr    wdata          exp_rdata      done strb
    vecs[0] = '{1'b0, 1'b1, 1'b1, 9'h0A5, 32'hDEADBEEF, 32'h0,         4, 1};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 9'h000, 32'h0,        32'h00000000,  4, 1};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 9'h0A5, 32'h0,        32'hDEADBEEF,  4, 1};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 9'h1FF, 32'h12345678, 32'h0,         4, 1};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 9'h1FF, 32'h0,        32'h12345678,  4, 1};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 9'h033, 32'hA5A55A5A, 32'h0,         5, 2};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 9'h033, 32'h0,        32'hA5A55A5A,  6, 3};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 9'h100, 32'h0BADF00D, 32'h0,         5, 2};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 9'h100, 32'h0,        32'h0BADF00D,  6, 3};

    // Reset state.
    #12;
    chk("reset_outputs", {22'd0, m_g0, m_g1, m_d0, m_d1, m_busy, m_bd, m_mar, m_mdr, m_rd, m_wr}, 32'd0);
    chk("reset_bus_out", m_bus, 32'd0);
    chk("reset_rdata", m_rdata, 32'd0);
    @(negedge clk); clr = 1'b1;

    for (int i = 0; i < 9; i++) do_access(vecs[i], i);

    // Reset asserted in the middle of a read.
    x_sel = 1'b0;
    got_read = 0;
    @(negedge clk);
    set_req(1'b0, 1'b0, 1'b1, 1'b0, 9'h0A5, 32'd0);
    for (int k = 1; k <= 6 && got_read == 0; k++) begin
      @(posedge clk); #1;
      if (m_g0) set_req(1'b0, 1'b0, 1'b0, 1'b0, 9'h0A5, 32'd0);
      if (m_rd) got_read = 1;
    end
    chk("reset_reached_read", got_read, 1);
    #2 clr = 1'b0;
    #1;
    chk("midread_reset_strobes",
        {22'd0, m_g0, m_g1, m_d0, m_d1, m_busy, m_bd, m_mar, m_mdr, m_rd, m_wr}, 32'd0);
    chk("midread_reset_rdata", m_rdata, 32'd0);
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 9'h0A5, 32'd0);
    @(negedge clk); clr = 1'b1;
    ev = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (m_busy || m_g0 || m_g1 || m_d0 || m_d1) ev++;
    end
    chk("idle_after_reset", ev, 0);

    // Round-robin with both requests held from reset.
    clr = 1'b0;
    set_req(1'b0, 1'b0, 1'b1, 1'b0, 9'h0A5, 32'd0);
    set_req(1'b0, 1'b1, 1'b1, 1'b0, 9'h1FF, 32'd0);
    @(negedge clk); clr = 1'b1;
    ng = 0; n0 = 0; n1 = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if ((m_g0 || m_g1) && ng < 4) begin gc[ng] = k; gw[ng] = m_g1; ng++; end
      if (m_d0 && n0 < 2) begin d0c[n0] = k; d0r[n0] = m_rdata; n0++; end
      if (m_d1 && n1 < 2) begin d1c[n1] = k; d1r[n1] = m_rdata; n1++; end
    end
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 9'h0, 32'd0);
    set_req(1'b0, 1'b1, 1'b0, 1'b0, 9'h0, 32'd0);
    chk("rr_gnt_count", ng, 4);
    chk("rr_done_counts", {n0[15:0], n1[15:0]}, {16'd2, 16'd2});
    if (ng == 4) begin
      chk("rr_gnt_order", {28'd0, gw[0], gw[1], gw[2], gw[3]}, {28'd0, 4'b0101});
      chk("rr_gnt_cycles", {gc[0][7:0], gc[1][7:0], gc[2][7:0], gc[3][7:0]},
          {8'd1, 8'd6, 8'd11, 8'd16});
    end
    if (n0 == 2 && n1 == 2) begin
      chk("rr_r0_done_cycles", {d0c[0][15:0], d0c[1][15:0]}, {16'd4, 16'd14});
      chk("rr_r1_done_cycles", {d1c[0][15:0], d1c[1][15:0]}, {16'd9, 16'd19});
      chk("rr_r0_rdata", d0r[0], 32'hDEADBEEF);
      chk("rr_r1_rdata", d1r[1], 32'h12345678);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
